// File: rtl/sample_packer.sv
// Sample FIFO plus byte serializer: buffers 32-bit {timestamp, channels} words and
// streams each one out as four little-endian bytes on a valid/ready interface.
module sample_packer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_save,
    input  logic [31:0]           i_data,
    input  logic                  i_run,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic [31:0] word;
    logic        load;
    logic        push;
    logic        drop;
    logic        run_p1;
    logic        run_rise;

    assign o_level  = level;
    assign o_empty  = (level == '0);
    assign o_full   = (level == LEVEL_FULL);
    assign o_byte   = word[{idx, 3'b000} +: 8];

    // A full FIFO still accepts a word when the serializer frees a slot on the same edge.
    assign push     = i_save && (!o_full || load);
    assign drop     = i_save && !push;
    assign run_rise = i_run && !run_p1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty) begin
                    load      = 1'b1;
                    idx_nxt   = 2'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    if (idx != 2'd3) begin
                        idx_nxt = idx + 2'd1;
                    end else if (!o_empty) begin
                        load    = 1'b1;
                        idx_nxt = 2'd0;
                    end else begin
                        idx_nxt   = 2'd0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            idx   <= 2'd0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                word <= mem[rd_ptr];
            end
        end
    end

    // Storage array carries data only, so it has no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, load})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // A drop on the same edge as a new capture start keeps the flag set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            run_p1     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            run_p1 <= i_run;
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (run_rise) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: a queue-based transaction model checked every
// cycle, plus hand-computed byte sequences and flag values per scenario.
module tb_sample_packer;

    logic        clk;
    logic        rst;
    logic        i_save;
    logic [31:0] i_data;
    logic        i_run;
    logic        i_ready;
    logic [7:0]  o_byte;
    logic        o_valid;
    logic [4:0]  o_level;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;

    int n_chk;
    int n_fail;
    int peak_level;
    int n_cyc;

    logic [31:0] mq[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] ser_word;
    int          ser_idx;
    bit          ser_valid;
    bit          m_ovf;
    bit          m_run_prev;

    sample_packer #(.DEPTH_LOG2(4)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_save     (i_save),
        .i_data     (i_data),
        .i_run      (i_run),
        .o_byte     (o_byte),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a word queue, a serializer holding one word, and the sticky flag.
    always @(posedge clk) begin
        bit hs;
        bit ld;
        int sz;
        if (rst) begin
            mq.delete();
            ser_word   = '0;
            ser_idx    = 0;
            ser_valid  = 0;
            m_ovf      = 0;
            m_run_prev = 0;
        end else begin
            sz = mq.size();
            hs = ser_valid && i_ready;
            ld = 0;
            if (hs) acc_q.push_back(ser_word[ser_idx*8 +: 8]);
            if (!ser_valid) begin
                ld = (sz > 0);
            end else if (hs) begin
                if (ser_idx < 3) ser_idx++;
                else if (sz > 0) ld = 1;
                else ser_valid = 0;
            end
            if (ld) begin
                ser_word  = mq.pop_front();
                ser_idx   = 0;
                ser_valid = 1;
            end
            if (i_save) begin
                if (sz < 16 || ld) mq.push_back(i_data);
                else m_ovf = 1;
            end else if (i_run && !m_run_prev) begin
                m_ovf = 0;
            end
            if (i_save && (sz < 16 || ld) && i_run && !m_run_prev) m_ovf = 0;
            m_run_prev = i_run;
        end
        #1;
        chk("valid", {31'd0, o_valid}, {31'd0, ser_valid});
        if (ser_valid) chk("byte", {24'd0, o_byte}, {24'd0, ser_word[ser_idx*8 +: 8]});
        chk("level", {27'd0, o_level}, mq.size());
        chk("empty", {31'd0, o_empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, o_full}, {31'd0, mq.size() == 16});
        chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
        if (int'(o_level) > peak_level) peak_level = int'(o_level);
    end

    task automatic do_reset();
        i_save  = 0;
        i_data  = '0;
        i_run   = 0;
        i_ready = 0;
        rst     = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        i_save = 1;
        i_data = w;
        @(negedge clk);
        i_save = 0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while ((o_valid || !o_empty) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", {31'd0, n < bound}, 32'd1);
    endtask

    task automatic check_acc(input string nm);
        chk({nm, "_count"}, acc_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
            chk(nm, {24'd0, acc_q[k]}, {24'd0, exp_q[k]});
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        peak_level = 0;
        rst = 0;
        i_save = 0;
        i_data = '0;
        i_run = 0;
        i_ready = 0;
        #1;
        rst = 1;
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_byte", {24'd0, o_byte}, 32'd0);
        chk("rst_level", {27'd0, o_level}, 32'd0);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        do_reset();

        // Single word: latency and little-endian order
        i_ready = 1;
        acc_q.delete();
        i_save = 1;
        i_data = 32'h0012_3456;
        @(negedge clk);
        i_save = 0;
        chk("single_valid_E", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        chk("single_valid_E1", {31'd0, o_valid}, 32'd1);
        chk("single_byte0", {24'd0, o_byte}, 32'h56);
        repeat (4) @(negedge clk);
        chk("single_done_valid", {31'd0, o_valid}, 32'd0);
        chk("single_done_empty", {31'd0, o_empty}, 32'd1);
        exp_q = {8'h56, 8'h34, 8'h12, 8'h00};
        check_acc("single");

        // Backpressure
        i_ready = 0;
        acc_q.delete();
        push_word(32'hAABB_CCDD);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_byte", {24'd0, o_byte}, 32'hDD);
        end
        i_ready = 1;
        wait_idle(20, n_cyc);
        exp_q = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        check_acc("stall");

        // Back-to-back words, no gaps
        acc_q.delete();
        peak_level = 0;
        push_word(32'h1122_3344);
        push_word(32'h5566_7788);
        push_word(32'h99AA_BBCC);
        wait_idle(40, n_cyc);
        chk("b2b_cycles", n_cyc, 32'd11);
        chk("b2b_peak", peak_level, 32'd2);
        exp_q = {8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                 8'hCC, 8'hBB, 8'hAA, 8'h99};
        check_acc("b2b");

        // Overflow: 18 pushes with the consumer stalled
        do_reset();
        acc_q.delete();
        for (int i = 0; i < 18; i++) begin
            i_save = 1;
            i_data = i;
            @(negedge clk);
            if (i == 16) begin
                chk("ovf_level16", {27'd0, o_level}, 32'd16);
                chk("ovf_full", {31'd0, o_full}, 32'd1);
            end
        end
        i_save = 0;
        chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
        i_ready = 1;
        wait_idle(120, n_cyc);
        exp_q.delete();
        for (int w = 0; w < 17; w++) exp_q = {exp_q, 8'(w), 8'h00, 8'h00, 8'h00};
        check_acc("ovf_drain");
        chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        i_run = 1;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, o_overflow}, 32'd0);
        i_run = 0;
        @(negedge clk);

        // Full FIFO with a pop on the same edge as the push
        do_reset();
        for (int i = 0; i < 17; i++) push_word(32'h100 + i);
        chk("fp_level", {27'd0, o_level}, 32'd16);
        acc_q.delete();
        i_ready = 1;
        repeat (3) @(negedge clk);
        i_save = 1;
        i_data = 32'hDEAD_BEEF;
        @(negedge clk);
        i_save = 0;
        chk("fp_level_hold", {27'd0, o_level}, 32'd16);
        chk("fp_full", {31'd0, o_full}, 32'd1);
        chk("fp_ovf", {31'd0, o_overflow}, 32'd0);
        wait_idle(120, n_cyc);
        chk("fp_count", acc_q.size(), 32'd72);
        if (acc_q.size() == 72) begin
            chk("fp_tail0", {24'd0, acc_q[68]}, 32'hEF);
            chk("fp_tail3", {24'd0, acc_q[71]}, 32'hDE);
        end

        // Reset in the middle of a word
        do_reset();
        for (int i = 0; i < 6; i++) push_word(32'h0A0B_0C00 + i);
        chk("rm_level", {27'd0, o_level}, 32'd5);
        i_ready = 1;
        repeat (2) @(negedge clk);
        i_ready = 0;
        rst = 1;
        #1;
        chk("rm_valid", {31'd0, o_valid}, 32'd0);
        chk("rm_level0", {27'd0, o_level}, 32'd0);
        chk("rm_empty", {31'd0, o_empty}, 32'd1);
        chk("rm_byte", {24'd0, o_byte}, 32'd0);
        @(negedge clk);
        rst = 0;
        acc_q.delete();
        i_ready = 1;
        push_word(32'h00C0_FFEE);
        wait_idle(20, n_cyc);
        exp_q = {8'hEE, 8'hFF, 8'hC0, 8'h00};
        check_acc("rm_fresh");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
